// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: start/busy/done handshake and operand/result bus for the iterative multiplier
interface seq_multiplier_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             unsigned_instr;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, multiplicand, multiplier, unsigned_instr,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, multiplicand, multiplier, unsigned_instr,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add 32x32->64 multiplier for MULT/MULTU writing HI/LO
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_multiplier_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_busy;
    logic               w_done;
    logic               w_accept;
    logic               w_signed;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_neg;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // New work is taken whenever the unit is not mid-run, which includes the DONE cycle
    assign w_accept = bus.start && (r_state != S_RUN);
    assign w_signed = !bus.unsigned_instr;
    assign w_a_mag  = (w_signed && bus.multiplicand[WIDTH-1]) ? -bus.multiplicand : bus.multiplicand;
    assign w_b_mag  = (w_signed && bus.multiplier[WIDTH-1])   ? -bus.multiplier   : bus.multiplier;

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state and status outputs; RUN spends its cnt==0 cycle applying the sign
    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: w_next = bus.start ? S_RUN : S_IDLE;
            S_RUN: begin
                w_busy = 1'b1;
                w_next = (r_cnt == '0) ? S_DONE : S_RUN;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = bus.start ? S_RUN : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: capture magnitudes, one shift-add step per RUN cycle, then sign-fix into HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_neg <= 1'b0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else if (w_accept) begin
            r_cnt <= CW'(WIDTH);
            r_acc <= '0;
            r_a   <= {{WIDTH{1'b0}}, w_a_mag};
            r_b   <= w_b_mag;
            r_neg <= w_signed && (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
        end else if (r_state == S_RUN) begin
            if (r_cnt != '0) begin
                r_acc <= r_acc + (r_b[0] ? r_a : '0);
                r_a   <= r_a << 1;
                r_b   <= r_b >> 1;
                r_cnt <= r_cnt - CW'(1);
            end else begin
                {r_hi, r_lo} <= r_neg ? -r_acc : r_acc;
            end
        end
    end
endmodule
